// File: rtl/billiard_pkg.sv
// Shared types for the billiard collision arbiter: FSM states, hit kinds,
// velocity container and the per-ball event priority function.
package billiard_pkg;

    localparam int VEL_W_DEFAULT = 11;
    localparam int HOLD_W        = 4;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_ISSUE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        HIT_NONE   = 2'd0,
        HIT_BORDER = 2'd1,
        HIT_BALL   = 2'd2,
        HIT_HOLE   = 2'd3
    } hit_kind_t;

    typedef logic signed [VEL_W_DEFAULT-1:0] vel_t;

    // Pocketing wins over any bounce; ball contact wins over a cushion.
    function automatic hit_kind_t pick_kind(input logic hole, input logic ball,
                                            input logic border);
        hit_kind_t k;
        if (hole)        k = HIT_HOLE;
        else if (ball)   k = HIT_BALL;
        else if (border) k = HIT_BORDER;
        else             k = HIT_NONE;
        return k;
    endfunction

endpackage

// File: rtl/hit_event_latch.sv
// Per-ball first-event latches (border, ball contact, hole) plus the
// holdoff counter that suppresses repeated bounce events after an update.
module hit_event_latch
    import billiard_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = 4,
    parameter int VEL_W          = VEL_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    capture,
    input  logic                    sof,
    input  logic                    clear,
    input  logic                    loadHoldoff,
    input  logic                    borderCol,
    input  logic signed [VEL_W-1:0] borderVelX,
    input  logic signed [VEL_W-1:0] borderVelY,
    input  logic                    ballCol,
    input  logic signed [VEL_W-1:0] ballVelX,
    input  logic signed [VEL_W-1:0] ballVelY,
    input  logic                    holeHit,
    output hit_kind_t               kind,
    output logic signed [VEL_W-1:0] velX,
    output logic signed [VEL_W-1:0] velY
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_FRAMES);

    logic                    borderSeen, ballSeen, holeSeen;
    logic signed [VEL_W-1:0] borderX, borderY, ballX, ballY;
    logic [HOLD_W-1:0]       holdCnt;
    logic                    eligible;

    assign eligible = (holdCnt == '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            borderSeen <= 1'b0;
            ballSeen   <= 1'b0;
            holeSeen   <= 1'b0;
            borderX    <= '0;
            borderY    <= '0;
            ballX      <= '0;
            ballY      <= '0;
        end else if (clear) begin
            borderSeen <= 1'b0;
            ballSeen   <= 1'b0;
            holeSeen   <= 1'b0;
        end else if (capture) begin
            // Only the first qualifying event of each kind in a frame sticks.
            if (holeHit) holeSeen <= 1'b1;
            if (eligible && borderCol && !borderSeen) begin
                borderSeen <= 1'b1;
                borderX    <= borderVelX;
                borderY    <= borderVelY;
            end
            if (eligible && ballCol && !ballSeen) begin
                ballSeen <= 1'b1;
                ballX    <= ballVelX;
                ballY    <= ballVelY;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            holdCnt <= '0;
        end else if (loadHoldoff) begin
            holdCnt <= HOLD_INIT;
        end else if (sof && holdCnt != '0) begin
            holdCnt <= holdCnt - 1'b1;
        end
    end

    always_comb begin
        kind = pick_kind(holeSeen, ballSeen, borderSeen);
        velX = borderX;
        velY = borderY;
        if (kind == HIT_BALL) begin
            velX = ballX;
            velY = ballY;
        end
    end

endmodule

// File: rtl/hit_arbiter.sv
// Frame-based collision arbiter: collects ball events, resolves priority and
// issues velocity loads. Optional hit counters under HIT_ARBITER_STATS_EN.
module hit_arbiter
    import billiard_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = 4,
    parameter int VEL_W          = VEL_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    whiteBorderCol,
    input  logic                    redBorderCol,
    input  logic signed [VEL_W-1:0] whiteBorderVelX,
    input  logic signed [VEL_W-1:0] whiteBorderVelY,
    input  logic signed [VEL_W-1:0] redBorderVelX,
    input  logic signed [VEL_W-1:0] redBorderVelY,
    input  logic                    ballToBallCol,
    input  logic signed [VEL_W-1:0] ballColWhiteVelX,
    input  logic signed [VEL_W-1:0] ballColWhiteVelY,
    input  logic signed [VEL_W-1:0] ballColRedVelX,
    input  logic signed [VEL_W-1:0] ballColRedVelY,
    input  logic                    whiteHoleHit,
    input  logic                    redHoleHit,
    output logic signed [VEL_W-1:0] whiteVelXOut,
    output logic signed [VEL_W-1:0] whiteVelYOut,
    output logic signed [VEL_W-1:0] redVelXOut,
    output logic signed [VEL_W-1:0] redVelYOut,
    output logic                    whiteVelUpdate,
    output logic                    redVelUpdate,
    output logic                    whitePocketed,
    output logic                    redPocketed,
    output logic                    busy,
    output arb_state_t              dbgState
`ifdef HIT_ARBITER_STATS_EN
    ,
    output logic [15:0]             whiteHitCount,
    output logic [15:0]             redHitCount
`endif
);

    arb_state_t              state, stateNext;
    hit_kind_t               whiteKind, redKind, whiteKindQ, redKindQ;
    logic signed [VEL_W-1:0] whiteVelX, whiteVelY, redVelX, redVelY;
    logic signed [VEL_W-1:0] whiteVelXQ, whiteVelYQ, redVelXQ, redVelYQ;
    logic                    collect, issue, ballChosen, whiteLoad, redLoad;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ST_COLLECT;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_COLLECT: if (startOfFrame) stateNext = ST_RESOLVE;
            ST_RESOLVE: stateNext = ST_ISSUE;
            ST_ISSUE:   stateNext = ST_COLLECT;
            default:    stateNext = ST_COLLECT;
        endcase
    end

    assign collect  = (state == ST_COLLECT);
    assign issue    = (state == ST_ISSUE);
    assign busy     = !collect;
    assign dbgState = state;

    // A ball-to-ball update puts both balls into holdoff, even one that
    // was itself ineligible for the contact this frame.
    assign ballChosen = (whiteKindQ == HIT_BALL) || (redKindQ == HIT_BALL);
    assign whiteLoad  = issue && ((whiteKindQ != HIT_NONE) || ballChosen);
    assign redLoad    = issue && ((redKindQ != HIT_NONE) || ballChosen);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            whiteKindQ <= HIT_NONE;
            redKindQ   <= HIT_NONE;
            whiteVelXQ <= '0;
            whiteVelYQ <= '0;
            redVelXQ   <= '0;
            redVelYQ   <= '0;
        end else if (state == ST_RESOLVE) begin
            whiteKindQ <= whiteKind;
            redKindQ   <= redKind;
            whiteVelXQ <= whiteVelX;
            whiteVelYQ <= whiteVelY;
            redVelXQ   <= redVelX;
            redVelYQ   <= redVelY;
        end
    end

    hit_event_latch #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES), .VEL_W(VEL_W)) u_white (
        .clk         (clk),
        .resetN      (resetN),
        .capture     (collect),
        .sof         (startOfFrame),
        .clear       (issue),
        .loadHoldoff (whiteLoad),
        .borderCol   (whiteBorderCol),
        .borderVelX  (whiteBorderVelX),
        .borderVelY  (whiteBorderVelY),
        .ballCol     (ballToBallCol),
        .ballVelX    (ballColWhiteVelX),
        .ballVelY    (ballColWhiteVelY),
        .holeHit     (whiteHoleHit),
        .kind        (whiteKind),
        .velX        (whiteVelX),
        .velY        (whiteVelY)
    );

    hit_event_latch #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES), .VEL_W(VEL_W)) u_red (
        .clk         (clk),
        .resetN      (resetN),
        .capture     (collect),
        .sof         (startOfFrame),
        .clear       (issue),
        .loadHoldoff (redLoad),
        .borderCol   (redBorderCol),
        .borderVelX  (redBorderVelX),
        .borderVelY  (redBorderVelY),
        .ballCol     (ballToBallCol),
        .ballVelX    (ballColRedVelX),
        .ballVelY    (ballColRedVelY),
        .holeHit     (redHoleHit),
        .kind        (redKind),
        .velX        (redVelX),
        .velY        (redVelY)
    );

    // Outputs are decoded from registered state so reset zeroes them at once.
    always_comb begin
        whiteVelXOut   = '0;
        whiteVelYOut   = '0;
        redVelXOut     = '0;
        redVelYOut     = '0;
        whiteVelUpdate = 1'b0;
        redVelUpdate   = 1'b0;
        whitePocketed  = 1'b0;
        redPocketed    = 1'b0;
        if (issue) begin
            whiteVelUpdate = (whiteKindQ != HIT_NONE);
            redVelUpdate   = (redKindQ != HIT_NONE);
            whitePocketed  = (whiteKindQ == HIT_HOLE);
            redPocketed    = (redKindQ == HIT_HOLE);
            if (whiteKindQ == HIT_BORDER || whiteKindQ == HIT_BALL) begin
                whiteVelXOut = whiteVelXQ;
                whiteVelYOut = whiteVelYQ;
            end
            if (redKindQ == HIT_BORDER || redKindQ == HIT_BALL) begin
                redVelXOut = redVelXQ;
                redVelYOut = redVelYQ;
            end
        end
    end

`ifdef HIT_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            whiteHitCount <= '0;
            redHitCount   <= '0;
        end else if (issue) begin
            if ((whiteKindQ == HIT_BORDER || whiteKindQ == HIT_BALL) &&
                whiteHitCount != 16'hFFFF)
                whiteHitCount <= whiteHitCount + 16'd1;
            if ((redKindQ == HIT_BORDER || redKindQ == HIT_BALL) &&
                redHitCount != 16'hFFFF)
                redHitCount <= redHitCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hit_arbiter.sv
// Directed self-checking bench for hit_arbiter (default HOLDOFF_FRAMES=4).
// Define HIT_ARBITER_STATS_EN to also exercise the hit counters.
module tb_hit_arbiter;
    import billiard_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic whiteBorderCol, redBorderCol, ballToBallCol, whiteHoleHit, redHoleHit;
    vel_t whiteBorderVelX, whiteBorderVelY, redBorderVelX, redBorderVelY;
    vel_t ballColWhiteVelX, ballColWhiteVelY, ballColRedVelX, ballColRedVelY;
    vel_t whiteVelXOut, whiteVelYOut, redVelXOut, redVelYOut;
    logic whiteVelUpdate, redVelUpdate, whitePocketed, redPocketed, busy;
    arb_state_t dbgState;
`ifdef HIT_ARBITER_STATS_EN
    logic [15:0] whiteHitCount, redHitCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic obs_wu, obs_ru, obs_wp, obs_rp;
    vel_t obs_wx, obs_wy, obs_rx, obs_ry;

    hit_arbiter #(.HOLDOFF_FRAMES(4), .VEL_W(VEL_W_DEFAULT)) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .whiteBorderCol   (whiteBorderCol),
        .redBorderCol     (redBorderCol),
        .whiteBorderVelX  (whiteBorderVelX),
        .whiteBorderVelY  (whiteBorderVelY),
        .redBorderVelX    (redBorderVelX),
        .redBorderVelY    (redBorderVelY),
        .ballToBallCol    (ballToBallCol),
        .ballColWhiteVelX (ballColWhiteVelX),
        .ballColWhiteVelY (ballColWhiteVelY),
        .ballColRedVelX   (ballColRedVelX),
        .ballColRedVelY   (ballColRedVelY),
        .whiteHoleHit     (whiteHoleHit),
        .redHoleHit       (redHoleHit),
        .whiteVelXOut     (whiteVelXOut),
        .whiteVelYOut     (whiteVelYOut),
        .redVelXOut       (redVelXOut),
        .redVelYOut       (redVelYOut),
        .whiteVelUpdate   (whiteVelUpdate),
        .redVelUpdate     (redVelUpdate),
        .whitePocketed    (whitePocketed),
        .redPocketed      (redPocketed),
        .busy             (busy),
        .dbgState         (dbgState)
`ifdef HIT_ARBITER_STATS_EN
        ,
        .whiteHitCount    (whiteHitCount),
        .redHitCount      (redHitCount)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        startOfFrame = 1'b0;
        whiteBorderCol = 1'b0; redBorderCol = 1'b0;
        ballToBallCol = 1'b0; whiteHoleHit = 1'b0; redHoleHit = 1'b0;
        whiteBorderVelX = '0; whiteBorderVelY = '0;
        redBorderVelX = '0; redBorderVelY = '0;
        ballColWhiteVelX = '0; ballColWhiteVelY = '0;
        ballColRedVelX = '0; ballColRedVelY = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    // Pulses startOfFrame and records outputs seen in the ISSUE cycle.
    task automatic issue_frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        obs_wu = whiteVelUpdate; obs_ru = redVelUpdate;
        obs_wp = whitePocketed;  obs_rp = redPocketed;
        obs_wx = whiteVelXOut;   obs_wy = whiteVelYOut;
        obs_rx = redVelXOut;     obs_ry = redVelYOut;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        resetN = 1'b0;
        #2;
        vectors++;
        if (busy !== 1'b0 || dbgState !== ST_COLLECT) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b state=%0d required busy=0 state=0", busy, dbgState);
        end
        vectors++;
        if ({whiteVelUpdate, redVelUpdate, whitePocketed, redPocketed} !== 4'b0 ||
            whiteVelXOut !== vel_t'(0) || redVelYOut !== vel_t'(0)) begin
            miscompares++;
            $display("FAIL reset_outputs: strobes=%b%b%b%b wx=%0d ry=%0d required all 0",
                     whiteVelUpdate, redVelUpdate, whitePocketed, redPocketed, whiteVelXOut, redVelYOut);
        end
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic test_border_latency();
        apply_reset();
        whiteBorderCol = 1'b1; whiteBorderVelX = vel_t'(-3); whiteBorderVelY = vel_t'(2);
        step();
        whiteBorderCol = 1'b0; whiteBorderVelX = vel_t'(9); whiteBorderVelY = vel_t'(9);
        step();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        vectors++;
        if (whiteVelUpdate !== 1'b0 || busy !== 1'b1 || dbgState !== ST_RESOLVE) begin
            miscompares++;
            $display("FAIL latency_cycle1: upd=%b busy=%b state=%0d required 0,1,1",
                     whiteVelUpdate, busy, dbgState);
        end
        step();
        vectors++;
        if (whiteVelUpdate !== 1'b1 || whiteVelXOut !== vel_t'(-3) || whiteVelYOut !== vel_t'(2)) begin
            miscompares++;
            $display("FAIL border_issue: upd=%b vel=(%0d,%0d) required 1 (-3,2)",
                     whiteVelUpdate, whiteVelXOut, whiteVelYOut);
        end
        vectors++;
        if (redVelUpdate !== 1'b0 || whitePocketed !== 1'b0) begin
            miscompares++;
            $display("FAIL border_others: redUpd=%b whitePock=%b required 0,0", redVelUpdate, whitePocketed);
        end
        step();
        vectors++;
        if (whiteVelUpdate !== 1'b0 || whiteVelXOut !== vel_t'(0) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL border_one_cycle: upd=%b vx=%0d busy=%b required 0,0,0",
                     whiteVelUpdate, whiteVelXOut, busy);
        end
    endtask

    task automatic test_ball_priority();
        apply_reset();
        whiteBorderCol = 1'b1; whiteBorderVelX = vel_t'(5); whiteBorderVelY = vel_t'(0);
        step();
        whiteBorderCol = 1'b0;
        ballToBallCol = 1'b1;
        ballColWhiteVelX = vel_t'(1); ballColWhiteVelY = vel_t'(1);
        ballColRedVelX = vel_t'(-2); ballColRedVelY = vel_t'(4);
        step();
        clear_inputs();
        issue_frame();
        vectors++;
        if (obs_wu !== 1'b1 || obs_wx !== vel_t'(1) || obs_wy !== vel_t'(1)) begin
            miscompares++;
            $display("FAIL ball_white: upd=%b vel=(%0d,%0d) required 1 (1,1)", obs_wu, obs_wx, obs_wy);
        end
        vectors++;
        if (obs_ru !== 1'b1 || obs_rx !== vel_t'(-2) || obs_ry !== vel_t'(4)) begin
            miscompares++;
            $display("FAIL ball_red: upd=%b vel=(%0d,%0d) required 1 (-2,4)", obs_ru, obs_rx, obs_ry);
        end
    endtask

    task automatic test_hole();
        apply_reset();
        redHoleHit = 1'b1; redBorderCol = 1'b1;
        redBorderVelX = vel_t'(7); redBorderVelY = vel_t'(-7);
        step();
        clear_inputs();
        issue_frame();
        vectors++;
        if (obs_rp !== 1'b1 || obs_ru !== 1'b1 || obs_rx !== vel_t'(0) || obs_ry !== vel_t'(0)) begin
            miscompares++;
            $display("FAIL hole_red: pock=%b upd=%b vel=(%0d,%0d) required 1,1 (0,0)",
                     obs_rp, obs_ru, obs_rx, obs_ry);
        end
        vectors++;
        if (obs_wp !== 1'b0 || obs_wu !== 1'b0) begin
            miscompares++;
            $display("FAIL hole_white_idle: pock=%b upd=%b required 0,0", obs_wp, obs_wu);
        end
    endtask

    task automatic test_frame_edges();
        apply_reset();
        // event on the startOfFrame cycle belongs to the closing frame
        whiteBorderCol = 1'b1; whiteBorderVelX = vel_t'(-8); whiteBorderVelY = vel_t'(3);
        startOfFrame = 1'b1;
        step();
        clear_inputs();
        // event while in RESOLVE must be dropped
        redBorderCol = 1'b1; redBorderVelX = vel_t'(6); redBorderVelY = vel_t'(6);
        step();
        clear_inputs();
        vectors++;
        if (whiteVelUpdate !== 1'b1 || whiteVelXOut !== vel_t'(-8) || whiteVelYOut !== vel_t'(3)) begin
            miscompares++;
            $display("FAIL coincident_event: upd=%b vel=(%0d,%0d) required 1 (-8,3)",
                     whiteVelUpdate, whiteVelXOut, whiteVelYOut);
        end
        step();
        issue_frame();
        vectors++;
        if (obs_ru !== 1'b0) begin
            miscompares++;
            $display("FAIL resolve_event_dropped: redUpd=%b required 0", obs_ru);
        end
    endtask

    task automatic test_holdoff();
        logic exp_upd;
        apply_reset();
        for (int f = 0; f < 7; f++) begin
            whiteBorderCol = 1'b1;
            whiteBorderVelX = vel_t'(f + 1); whiteBorderVelY = vel_t'(-1);
            step();
            whiteBorderCol = 1'b0;
            step();
            issue_frame();
            exp_upd = (f == 0 || f == 5);
            vectors++;
            if (obs_wu !== exp_upd) begin
                miscompares++;
                $display("FAIL holdoff_frame%0d: upd=%b required %b", f, obs_wu, exp_upd);
            end
            if (exp_upd) begin
                vectors++;
                if (obs_wx !== vel_t'(f + 1) || obs_wy !== vel_t'(-1)) begin
                    miscompares++;
                    $display("FAIL holdoff_vel%0d: vel=(%0d,%0d) required (%0d,-1)", f, obs_wx, obs_wy, f + 1);
                end
            end
        end
        // hole events ignore holdoff (white is in holdoff after frame 5)
        whiteHoleHit = 1'b1;
        step();
        whiteHoleHit = 1'b0;
        issue_frame();
        vectors++;
        if (obs_wp !== 1'b1 || obs_wu !== 1'b1) begin
            miscompares++;
            $display("FAIL hole_during_holdoff: pock=%b upd=%b required 1,1", obs_wp, obs_wu);
        end
    endtask

    task automatic test_reset_in_resolve();
        apply_reset();
        whiteBorderCol = 1'b1; whiteBorderVelX = vel_t'(4); whiteBorderVelY = vel_t'(4);
        step();
        whiteBorderCol = 1'b0;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        resetN = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || dbgState !== ST_COLLECT || whiteVelUpdate !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_resolve: busy=%b state=%0d upd=%b required 0,0,0",
                     busy, dbgState, whiteVelUpdate);
        end
        step();
        resetN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (whiteVelUpdate !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_cycle%0d: upd=%b busy=%b required 0,0", c, whiteVelUpdate, busy);
            end
        end
        issue_frame();
        vectors++;
        if (obs_wu !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_latch_cleared: upd=%b required 0", obs_wu);
        end
    endtask

`ifdef HIT_ARBITER_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            whiteBorderCol = 1'b1; whiteBorderVelX = vel_t'(2); whiteBorderVelY = vel_t'(2);
            step();
            whiteBorderCol = 1'b0;
            issue_frame();
            for (int e = 0; e < 4; e++) issue_frame();
        end
        whiteHoleHit = 1'b1;
        step();
        whiteHoleHit = 1'b0;
        issue_frame();
        vectors++;
        if (whiteHitCount !== 16'd3 || redHitCount !== 16'd0) begin
            miscompares++;
            $display("FAIL hit_count: white=%0d red=%0d required 3,0", whiteHitCount, redHitCount);
        end
    endtask
`endif

    // sequence and final report
    initial begin
        clear_inputs();
        test_reset();
        test_border_latency();
        test_ball_priority();
        test_hole();
        test_frame_edges();
        test_holdoff();
        test_reset_in_resolve();
`ifdef HIT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
